// File: rtl/loadq_alloc_pkg.sv
// Shared load-queue types and helpers: entry id, static payload, nuke packet,
// rotating find-first, popcount and one-hot decode.
package loadq_alloc_pkg;

  localparam int LDQ_NUM_ENTRIES     = 8;
  localparam int LDQ_RESERVE_ENTRIES = 1;
  localparam int LDQ_ID_W            = $clog2(LDQ_NUM_ENTRIES);
  localparam int LDQ_CNT_W           = LDQ_ID_W + 1;

  typedef logic [LDQ_ID_W-1:0]        t_ldq_id;
  typedef logic [LDQ_NUM_ENTRIES-1:0] t_ldq_age_row;
  typedef logic [LDQ_CNT_W-1:0]       t_ldq_cnt;

  typedef struct packed {
    logic [6:0] robid;
    logic [1:0] simid;
  } t_ldq_static;

  typedef struct packed {
    logic       valid;
    logic [6:0] robid;
  } t_nuke_pkt;

  // First set bit at or above start, wrapping; the id width makes the wrap free.
  function automatic t_ldq_id rr_find_first(input t_ldq_age_row vec, input t_ldq_id start);
    t_ldq_id idx;
    logic    found;
    rr_find_first = start;
    found         = 1'b0;
    for (int k = 0; k < LDQ_NUM_ENTRIES; k++) begin
      idx = start + t_ldq_id'(k);
      if (vec[idx] && !found) begin
        rr_find_first = idx;
        found         = 1'b1;
      end
    end
  endfunction

  function automatic t_ldq_cnt popcount(input t_ldq_age_row vec);
    popcount = '0;
    for (int i = 0; i < LDQ_NUM_ENTRIES; i++) begin
      popcount = popcount + t_ldq_cnt'(vec[i]);
    end
  endfunction

  function automatic t_ldq_age_row onehot(input t_ldq_id id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

endpackage

// File: rtl/loadq_age_matrix.sv
// NxN age matrix (age[i][j]=1: i younger than j) with oldest-requester select.
// Parameterised on N so the store queue can reuse it.
module loadq_age_matrix
  import loadq_alloc_pkg::*;
#(
  parameter int N = LDQ_NUM_ENTRIES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alloc_vld,
  input  logic [$clog2(N)-1:0] alloc_id,
  input  logic [N-1:0]         valid,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         oldest
);

  localparam int IW = $clog2(N);

  logic [N-1:0] age_r [N];

  // New entry is younger than every live entry; nobody is younger than it yet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        age_r[i] <= '0;
      end
    end else if (alloc_vld) begin
      for (int i = 0; i < N; i++) begin
        if (IW'(i) == alloc_id) begin
          age_r[i] <= valid & ~(N'(1) << alloc_id);
        end else begin
          age_r[i][alloc_id] <= 1'b0;
        end
      end
    end
  end

  // A requester wins when no live requesting entry is older than it.
  always_comb begin
    oldest = '0;
    for (int i = 0; i < N; i++) begin
      oldest[i] = reset_n & req[i] & ~|(age_r[i] & req & valid);
    end
  end

endmodule

// File: rtl/loadq_alloc_chk.sv
// Property checker for loadq_alloc: count settles, grants hit free entries,
// oldest select is one-hot or zero, occupancy never exceeds the queue.
module loadq_alloc_chk
  import loadq_alloc_pkg::*;
(
  input logic         clk,
  input logic         reset_n,
  input logic         alloc_gnt_rs0,
  input t_ldq_age_row e_alloc_rs0,
  input t_ldq_age_row e_valid,
  input t_ldq_age_row ldq_oldest_req_mm0,
  input t_ldq_cnt     ldq_count
);

  a_count_settles: assert property (@(posedge clk) disable iff (!reset_n)
    (!alloc_gnt_rs0 && !$past(alloc_gnt_rs0) && (e_valid == $past(e_valid)))
      |=> (ldq_count == t_ldq_cnt'($countones($past(e_valid)))));

  a_alloc_free: assert property (@(posedge clk) disable iff (!reset_n)
    ((e_alloc_rs0 & e_valid) == '0));

  a_oldest_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(ldq_oldest_req_mm0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    (ldq_count <= t_ldq_cnt'(LDQ_NUM_ENTRIES)));

endmodule

// File: rtl/loadq_alloc.sv
// Load-queue allocator: round-robin free-entry grant, occupancy count and
// oldest-requester select. Optional macro LDQ_ALLOC_RESERVE_EN holds back
// entries for the ROB-head load.
module loadq_alloc
  import loadq_alloc_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         alloc_req_rs0,
  input  t_ldq_static  alloc_static_rs0,
  input  logic         alloc_rob_head_rs0,
  output logic         alloc_gnt_rs0,
  output t_ldq_id      alloc_id_rs0,
  output logic         ldq_full_rs0,
  output t_ldq_age_row e_alloc_rs0,
  output t_ldq_static  q_alloc_static_rs0,
  input  t_ldq_age_row e_valid,
  input  t_ldq_age_row e_pipe_req_mm0,
  output t_ldq_age_row ldq_oldest_req_mm0,
  input  t_nuke_pkt    nuke_rb1,
  output t_ldq_cnt     ldq_count
);

  t_ldq_id      rr_ptr_r;
  t_ldq_age_row e_valid_q_r;
  logic         nuke_blk_r;
  t_ldq_cnt     ldq_count_r;
  t_ldq_age_row free_s;
  logic         reserve_blk_s;
  logic         unused_s;

  assign free_s             = ~e_valid;
  assign alloc_id_rs0       = rr_find_first(free_s, rr_ptr_r);
  assign q_alloc_static_rs0 = alloc_static_rs0;
  assign ldq_count          = ldq_count_r;

`ifdef LDQ_ALLOC_RESERVE_EN
  assign reserve_blk_s = (popcount(free_s) <= t_ldq_cnt'(LDQ_RESERVE_ENTRIES)) & ~alloc_rob_head_rs0;
  assign unused_s      = ^nuke_rb1.robid;
`else
  assign reserve_blk_s = 1'b0;
  assign unused_s      = ^{alloc_rob_head_rs0, nuke_rb1.robid};
`endif

  // Full/grant decode; the grant is held low while reset is asserted.
  always_comb begin
    ldq_full_rs0  = (free_s == '0) | nuke_rb1.valid | nuke_blk_r | reserve_blk_s;
    alloc_gnt_rs0 = alloc_req_rs0 & ~ldq_full_rs0 & reset_n;
    if (alloc_gnt_rs0) begin
      e_alloc_rs0 = onehot(alloc_id_rs0);
    end else begin
      e_alloc_rs0 = '0;
    end
  end

  // Pointer advance, nuke drain window and occupancy from valid falling edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r    <= '0;
      e_valid_q_r <= '0;
      nuke_blk_r  <= 1'b0;
      ldq_count_r <= '0;
    end else begin
      e_valid_q_r <= e_valid;
      nuke_blk_r  <= nuke_rb1.valid;
      ldq_count_r <= ldq_count_r + t_ldq_cnt'(alloc_gnt_rs0) - popcount(e_valid_q_r & ~e_valid);
      if (alloc_gnt_rs0) begin
        rr_ptr_r <= alloc_id_rs0 + t_ldq_id'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  loadq_age_matrix #(
    .N (LDQ_NUM_ENTRIES)
  ) u_age (
    .clk       (clk),
    .reset_n   (reset_n),
    .alloc_vld (alloc_gnt_rs0),
    .alloc_id  (alloc_id_rs0),
    .valid     (e_valid),
    .req       (e_pipe_req_mm0),
    .oldest    (ldq_oldest_req_mm0)
  );

endmodule
